// File: rtl/rom_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, drives the ROM address and
// buffers fetched words in a 2-entry FIFO toward decode over valid/ready.
module rom_fetch_ctrl #(
  parameter int              AW         = 9,
  parameter int              DW         = 32,
  parameter logic [AW-1:0]   START_ADDR = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch_en,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_addr,
  output logic          out_valid,
  output logic [DW-1:0] out_instr,
  output logic [AW-1:0] out_pc,
  input  logic          out_ready
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] redirect_pc;
  logic [AW-1:0] buf_pc    [2];
  logic [DW-1:0] buf_instr [2];
  logic          head;
  logic          tail;
  logic [1:0]    count;
  logic [AW-1:0] hold_pc;
  logic [DW-1:0] hold_instr;
  logic          push;
  logic          pop;

  assign rom_addr    = fetch_pc;
  assign redirect_pc = redirect_addr & {{(AW-2){1'b1}}, 2'b00};

  // A full buffer may still accept a new word when the head leaves in the same cycle.
  assign pop  = out_valid && out_ready;
  assign push = (state == RUN) && fetch_en && !redirect_valid &&
                ((count < 2'd2) || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fetch_en)  state_next = RUN;
      RUN:     if (!fetch_en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= START_ADDR;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
    end else if (push) begin
      fetch_pc <= fetch_pc + AW'(4);
    end
  end

  // Redirect discards every buffered entry, including one popped in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else if (redirect_valid) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) tail <= ~tail;
      if (pop)  head <= ~head;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_pc[0]    <= '0;
      buf_pc[1]    <= '0;
      buf_instr[0] <= '0;
      buf_instr[1] <= '0;
    end else if (push) begin
      buf_pc[tail]    <= fetch_pc;
      buf_instr[tail] <= rom_data;
    end
  end

  // Keeps the most recently presented head so the outputs stay stable while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_pc    <= '0;
      hold_instr <= '0;
    end else if (count != 2'd0) begin
      hold_pc    <= buf_pc[head];
      hold_instr <= buf_instr[head];
    end
  end

  assign out_valid = (count != 2'd0);
  assign out_pc    = out_valid ? buf_pc[head]    : hold_pc;
  assign out_instr = out_valid ? buf_instr[head] : hold_instr;

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Directed bench for rom_fetch_ctrl: a scoreboard queue of expected fetch PCs is
// filled by the stimulus and drained by a monitor on every accepted handshake.
module tb_rom_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic [8:0]  rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [8:0]  redirect_addr;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [8:0]  out_pc;
  logic        out_ready;

  int          checks = 0;
  int          errors = 0;
  logic [8:0]  exp_q[$];

  rom_fetch_ctrl #(
    .AW(9),
    .DW(32),
    .START_ADDR(9'h000)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .fetch_en(fetch_en),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr),
    .out_valid(out_valid),
    .out_instr(out_instr),
    .out_pc(out_pc),
    .out_ready(out_ready)
  );

  assign rom_data = 32'hA000_0000 | {23'd0, rom_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
    end
  endtask

  task automatic push_exp(input logic [8:0] pc);
    exp_q.push_back(pc);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Handshakes are sampled on the falling edge; inputs only change just after rising edges.
  initial begin
    logic [8:0] exp_pc;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb_unexpected actual_pc=0x%0h required=none", out_pc);
        end else begin
          exp_pc = exp_q.pop_front();
          check_output("sb_pc", {23'd0, out_pc}, {23'd0, exp_pc});
          check_output("sb_instr", out_instr, 32'hA000_0000 | {23'd0, exp_pc});
        end
      end
    end
  end

  task automatic apply_stimulus();
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = 9'h000;
    #2;
    check_output("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("rst_rom_addr", {23'd0, rom_addr}, 32'h000);
    check_output("rst_out_pc", {23'd0, out_pc}, 32'h000);
    check_output("rst_out_instr", out_instr, 32'h0);

    // Reset then enable
    step(1);
    rst_n     = 1'b1;
    fetch_en  = 1'b1;
    out_ready = 1'b1;
    push_exp(9'h000); push_exp(9'h004); push_exp(9'h008); push_exp(9'h00C);
    step(1);
    check_output("e0_no_push_valid", {31'd0, out_valid}, 32'd0);
    check_output("e0_rom_addr", {23'd0, rom_addr}, 32'h000);
    step(1);
    check_output("e1_out_valid", {31'd0, out_valid}, 32'd1);

    // Asynchronous reset between edges
    step(4);
    out_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check_output("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("arst_rom_addr", {23'd0, rom_addr}, 32'h000);

    // Restart under back-pressure
    #4;
    rst_n    = 1'b1;
    fetch_en = 1'b1;
    push_exp(9'h000); push_exp(9'h004);
    step(2);
    check_output("restart_valid", {31'd0, out_valid}, 32'd1);
    check_output("restart_pc", {23'd0, out_pc}, 32'h000);
    step(3);
    check_output("bp_rom_addr", {23'd0, rom_addr}, 32'h008);
    check_output("bp_out_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;

    // Redirect with misaligned target while full
    step(1);
    redirect_valid = 1'b1;
    redirect_addr  = 9'h0A7;
    push_exp(9'h0A4); push_exp(9'h0A8);
    step(1);
    redirect_valid = 1'b0;
    check_output("redir_flush_valid", {31'd0, out_valid}, 32'd0);
    check_output("redir_rom_addr", {23'd0, rom_addr}, 32'h0A4);

    // Wrap-around
    step(2);
    redirect_valid = 1'b1;
    redirect_addr  = 9'h1F8;
    push_exp(9'h1F8); push_exp(9'h1FC); push_exp(9'h000); push_exp(9'h004);
    step(1);
    redirect_valid = 1'b0;
    check_output("wrap_flush_valid", {31'd0, out_valid}, 32'd0);
    step(4);
    out_ready = 1'b0;

    // Stop and drain with two entries buffered
    step(1);
    fetch_en  = 1'b0;
    out_ready = 1'b1;
    push_exp(9'h008);
    check_output("drain_full_valid", {31'd0, out_valid}, 32'd1);
    check_output("drain_rom_addr0", {23'd0, rom_addr}, 32'h00C);
    step(1);
    check_output("drain_rom_addr1", {23'd0, rom_addr}, 32'h00C);
    step(1);
    check_output("drain_empty_valid", {31'd0, out_valid}, 32'd0);
    check_output("drain_rom_addr2", {23'd0, rom_addr}, 32'h00C);
    check_output("drain_hold_pc", {23'd0, out_pc}, 32'h008);
    check_output("drain_hold_instr", out_instr, 32'hA000_0008);
    step(3);
    check_output("idle_valid", {31'd0, out_valid}, 32'd0);
    check_output("sb_remaining", exp_q.size(), 32'd0);
  endtask

  initial begin
    apply_stimulus();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_fetch_ctrl.md
# rom_fetch_ctrl

Instruction-fetch sequencer for the PA-RISC core's instruction ROM (`rom`: 9-bit byte address in, 32-bit word out, combinational).
It owns the fetch program counter and drives the ROM address every cycle.
Each word read is captured together with its address into a 2-entry prefetch buffer, which is presented to the decode stage over a valid/ready handshake.
It also handles branch redirects (flushing stale prefetches) and fetch enable/stop.

## Interface
- `AW`, 9: ROM byte-address width; the address space wraps modulo 2^AW.
- `DW`, 32: instruction width.
- `START_ADDR`, 0: fetch PC value after reset; must be word-aligned.
- `clk`  in  1: the single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `fetch_en`  in  1: permits fetching; sampled each edge.
- `rom_addr`  out  AW: address driven to the ROM; always equals the fetch PC.
- `rom_data`  in  DW: ROM output for `rom_addr`, valid in the same cycle.
- `redirect_valid`  in  1: load a new fetch PC and flush the buffer.
- `redirect_addr`  in  AW: target of the redirect.
- `out_valid`  out  1: buffer head holds an instruction.
- `out_instr`  out  DW: instruction at the buffer head.
- `out_pc`  out  AW: address the head instruction was fetched from.
- `out_ready`  in  1: the consumer accepts the head this cycle.

## Operation
- **FSM states:**
  - IDLE: no fetches.
  - RUN: fetching.
- **Reset values:** state=IDLE, fetch PC=`START_ADDR` (so `rom_addr`=`START_ADDR`), buffer count=0, `out_valid`=0, `out_instr`=0, `out_pc`=0.
- **State transitions:**
  - IDLE→RUN on an edge with `fetch_en`=1; no push occurs on that edge.
  - RUN→IDLE on an edge with `fetch_en`=0; no push occurs on that edge.
  - Buffered entries are kept in IDLE and continue to drain.
- **pop** is true when `out_valid`=1 and `out_ready`=1. A pop with an empty buffer has no effect.
- **push** is true when all of the following hold:
  - state=RUN and `fetch_en`=1;
  - `redirect_valid`=0;
  - count<2, or count==2 and pop is true this cycle.
- **On push:**
  - the entry {fetch PC, `rom_data`} is written at the tail;
  - fetch PC <= (fetch PC + 4) mod 2^AW, so 0x1FC is followed by 0x000.
- **Buffer:** 2-entry FIFO in strict order. Count is updated by +push −pop, and 2 is never exceeded. `out_valid`=(count≠0). `out_instr` and `out_pc` are driven from the head entry; when empty they hold their last value (0 after reset).
- **Redirect** (`redirect_valid`=1, in either state):
  - count <= 0;
  - fetch PC <= `redirect_addr` with bits [1:0] forced to 0;
  - no push on that edge;
  - the state follows the normal `fetch_en` rules.
  - A pop in the same cycle is still counted as accepted by the consumer, but the resulting buffer is empty.
- **Priority:** reset > redirect > push/pop.

## Timing
- ROM access is combinational: `rom_addr` changes after the edge, and `rom_data` must settle within the cycle before the next edge captures it.
- **Fetch latency:** `fetch_en` is raised before edge E0 (IDLE→RUN). The first push happens at E1, so `out_valid`=1 after E1.
- **Steady state:** with `out_ready` held at 1, one instruction is delivered per cycle with consecutive PCs.
- **Redirect latency:** redirect is asserted before edge R. `out_valid`=0 after R, and the instruction from the target is at the head after R+1.
- **Back-pressure:** with `out_ready`=0 the buffer fills to 2, then fetch PC and `rom_addr` freeze until a pop.
- **Reset mid-operation:** asserting `rst_n` low immediately (asynchronously) restores all reset values, discards buffered entries, and returns the state to IDLE.

## Test plan
The bench ROM model returns 32'hA000_0000 | addr for every address.

- **Reset then enable:**
  - Stimulus: release `rst_n`, raise `fetch_en`, keep `out_ready`=1.
  - Required: `out_valid` first rises after the 2nd edge with `out_pc`=0x000 and `out_instr`=0xA0000000. The following cycles give PCs 0x004, 0x008, 0x00C.
- **Back-pressure:**
  - Stimulus: `out_ready`=0 for 5 cycles while running, then `out_ready`=1.
  - Required: count saturates at 2, `rom_addr` stays at 0x008, and the entries drain as 0x000 and 0x004 with no gaps or duplicates.
- **Redirect with misaligned target:**
  - Stimulus: with the buffer full, assert `redirect_valid` with `redirect_addr`=0x0A7 and `out_ready`=1.
  - Required: `out_valid`=0 for one cycle, then `out_pc`=0x0A4, `out_instr`=0xA00000A4, followed by 0x0A8.
- **Wrap-around:**
  - Stimulus: redirect to 0x1F8 and run.
  - Required: the sequence is 0x1F8, 0x1FC, 0x000, 0x004.
- **Stop and drain:**
  - Stimulus: drop `fetch_en` with 2 entries buffered and `out_ready`=1.
  - Required: both entries are delivered, `rom_addr` does not advance, and `out_valid`=0 afterwards.
- **Asynchronous reset mid-stream:**
  - Stimulus: pull `rst_n` low between edges while running.
  - Required: `out_valid`=0 and `rom_addr`=`START_ADDR` before the next edge. Restarting reproduces the reset-then-enable scenario.
